// File: rtl/spi_cmd_decoder_pkg.sv
// rtl/spi_cmd_decoder_pkg.sv - register map, FSM states and fill bytes shared by the SPI command decoder
package spi_cmd_decoder_pkg;

    localparam logic [6:0] REG_ID     = 7'h00;
    localparam logic [6:0] REG_LED    = 7'h01;
    localparam logic [6:0] REG_STATUS = 7'h7F;

    localparam logic [7:0] FILL_RUNOFF = 8'hFF;
    localparam logic [7:0] FILL_ERROR  = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_RD    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // STATUS lives at the top of the 7-bit space, outside the contiguous block
    function automatic logic addr_ok(input logic [6:0] addr, input logic [7:0] num_regs);
        return ({1'b0, addr} < num_regs) || (addr == REG_STATUS);
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// rtl/spi_cmd_decoder_if.sv - received-byte / transmit-load handshake between SPI slave and decoder
interface spi_cmd_decoder_if;

    logic [7:0] i_rx_byte;
    logic       i_rx_valid;
    logic       i_cs_n;
    logic [7:0] o_tx_byte;
    logic       o_tx_load;

    modport master (
        output i_rx_byte, i_rx_valid, i_cs_n,
        input  o_tx_byte, o_tx_load
    );

    modport slave (
        input  i_rx_byte, i_rx_valid, i_cs_n,
        output o_tx_byte, o_tx_load
    );

endinterface

// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - register storage with RO/RW masking and combinational read mux
module spi_regfile
    import spi_cmd_decoder_pkg::*;
#(
    parameter int         NUM_REGS = 4,
    parameter logic [7:0] ID_VALUE = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [6:0] rd_addr,
    input  logic [7:0] status,
    output logic [7:0] rd_data,
    output logic [3:0] led
);

    // Slots 0 and 1 are ID and LED; only 2..NUM_REGS-1 hold scratch data
    logic [7:0] scratch [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 4'h0;
            for (int i = 2; i < NUM_REGS; i++) begin
                scratch[i] <= 8'h00;
            end
        end else if (wr_en) begin
            if (wr_addr == REG_LED) begin
                led <= wr_data[3:0];
            end
            for (int i = 2; i < NUM_REGS; i++) begin
                if (wr_addr == 7'(i)) begin
                    scratch[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr == REG_ID) begin
            rd_data = ID_VALUE;
        end else if (rd_addr == REG_LED) begin
            rd_data = {4'h0, led};
        end else if (rd_addr == REG_STATUS) begin
            rd_data = status;
        end else begin
            for (int i = 2; i < NUM_REGS; i++) begin
                if (rd_addr == 7'(i)) begin
                    rd_data = scratch[i];
                end
            end
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - framed register protocol decoder behind the SPI slave receive path
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int         NUM_REGS = 4,
    parameter logic [7:0] ID_VALUE = 8'h5A
) (
    input  logic               clk_12MHz,
    input  logic               i_rst,
    spi_cmd_decoder_if.slave   bus,
    output logic               o_err,
    output logic               led_0,
    output logic               led_1,
    output logic               led_2,
    output logic               led_3
);

    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    state_t     state, state_n;
    logic [6:0] addr, addr_n, addr_inc, cmd_addr, rd_addr;
    logic [3:0] err_cnt, err_cnt_n;
    logic       err_n;
    logic [7:0] tx_byte_n;
    logic       tx_load_n;
    logic       wr_en;
    logic [7:0] rd_data;
    logic [7:0] status;
    logic [3:0] led;

    assign cmd_addr = bus.i_rx_byte[6:0];
    assign addr_inc = addr + 7'd1;
    assign status   = {o_err, 3'b000, err_cnt};
    // In IDLE the command byte addresses the read; in RD the prefetch is one ahead
    assign rd_addr  = (state == ST_IDLE) ? cmd_addr : addr_inc;

    spi_regfile #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk     (clk_12MHz),
        .rst     (i_rst),
        .wr_en   (wr_en),
        .wr_addr (addr),
        .wr_data (bus.i_rx_byte),
        .rd_addr (rd_addr),
        .status  (status),
        .rd_data (rd_data),
        .led     (led)
    );

    always_ff @(posedge clk_12MHz) begin
        if (i_rst) begin
            state         <= ST_DRAIN;
            addr          <= 7'h00;
            err_cnt       <= 4'h0;
            o_err         <= 1'b0;
            bus.o_tx_byte <= 8'h00;
            bus.o_tx_load <= 1'b0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            err_cnt       <= err_cnt_n;
            o_err         <= err_n;
            bus.o_tx_byte <= tx_byte_n;
            bus.o_tx_load <= tx_load_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        err_cnt_n = err_cnt;
        err_n     = o_err;
        tx_byte_n = bus.o_tx_byte;
        tx_load_n = 1'b0;
        wr_en     = 1'b0;

        if (bus.i_cs_n) begin
            state_n = ST_IDLE;
        end else if (bus.i_rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (addr_ok(cmd_addr, NUM_REGS_B)) begin
                        addr_n = cmd_addr;
                        if (bus.i_rx_byte[7]) begin
                            state_n = ST_WR;
                        end else begin
                            state_n   = ST_RD;
                            tx_byte_n = rd_data;
                            tx_load_n = 1'b1;
                        end
                    end else begin
                        err_n     = 1'b1;
                        err_cnt_n = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;
                        tx_byte_n = FILL_ERROR;
                        tx_load_n = 1'b1;
                        state_n   = ST_DRAIN;
                    end
                end
                ST_WR: begin
                    wr_en  = 1'b1;
                    addr_n = addr_inc;
                    if (addr == REG_STATUS) begin
                        err_n     = 1'b0;
                        err_cnt_n = 4'h0;
                    end
                    if (!addr_ok(addr_inc, NUM_REGS_B)) begin
                        state_n = ST_DRAIN;
                    end
                end
                ST_RD: begin
                    addr_n    = addr_inc;
                    tx_load_n = 1'b1;
                    if (addr_ok(addr_inc, NUM_REGS_B)) begin
                        tx_byte_n = rd_data;
                    end else begin
                        tx_byte_n = FILL_RUNOFF;
                        state_n   = ST_DRAIN;
                    end
                end
                default: begin
                    state_n = ST_DRAIN;
                end
            endcase
        end
    end

    assign led_0 = led[0];
    assign led_1 = led[1];
    assign led_2 = led[2];
    assign led_3 = led[3];

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb/tb_spi_cmd_decoder.sv - randomized bench for spi_cmd_decoder against a register-map reference model
module tb_spi_cmd_decoder;

    localparam int         NUM_REGS = 4;
    localparam logic [7:0] ID_VALUE = 8'h5A;
    localparam int M_IDLE  = 0;
    localparam int M_WR    = 1;
    localparam int M_RD    = 2;
    localparam int M_DRAIN = 3;

    logic clk = 1'b0;
    logic rst;
    logic err;
    logic led_0, led_1, led_2, led_3;

    always #5 clk = ~clk;

    spi_cmd_decoder_if bus();

    spi_cmd_decoder #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) dut (
        .clk_12MHz (clk),
        .i_rst     (rst),
        .bus       (bus),
        .o_err     (err),
        .led_0     (led_0),
        .led_1     (led_1),
        .led_2     (led_2),
        .led_3     (led_3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_regs [128];
    logic       m_err;
    int         m_cnt;
    int         m_addr;
    int         m_mode;
    logic [7:0] m_tx;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_valid(input int a);
        return (a < NUM_REGS) || (a == 127);
    endfunction

    function automatic logic [7:0] m_read(input int a);
        if (a == 0)   return ID_VALUE;
        if (a == 127) return {m_err, 3'b000, 4'(m_cnt)};
        return m_regs[a];
    endfunction

    task automatic m_write(input int a, input logic [7:0] d);
        if (a == 1) m_regs[1] = d & 8'h0F;
        else if (a >= 2 && a < NUM_REGS) m_regs[a] = d;
        else if (a == 127) begin
            m_err = 1'b0;
            m_cnt = 0;
        end
    endtask

    function automatic logic [3:0] leds();
        return {led_3, led_2, led_1, led_0};
    endfunction

    task automatic check_outputs(input bit exp_load);
        check_eq("tx_load", bus.o_tx_load, exp_load);
        check_eq("tx_byte", bus.o_tx_byte, m_tx);
        check_eq("leds", leds(), m_regs[1][3:0]);
        check_eq("err", err, m_err);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit exp_load;
        int a;
        exp_load = 1'b0;
        @(negedge clk);
        bus.i_rx_byte  = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
        case (m_mode)
            M_IDLE: begin
                a = int'(b[6:0]);
                if (m_valid(a)) begin
                    m_addr = a;
                    if (b[7]) m_mode = M_WR;
                    else begin
                        m_mode = M_RD;
                        m_tx = m_read(a);
                        exp_load = 1'b1;
                    end
                end else begin
                    m_err = 1'b1;
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                    m_tx = 8'hEE;
                    exp_load = 1'b1;
                    m_mode = M_DRAIN;
                end
            end
            M_WR: begin
                m_write(m_addr, b);
                m_addr = (m_addr + 1) % 128;
                if (!m_valid(m_addr)) m_mode = M_DRAIN;
            end
            M_RD: begin
                m_addr = (m_addr + 1) % 128;
                exp_load = 1'b1;
                if (m_valid(m_addr)) m_tx = m_read(m_addr);
                else begin
                    m_tx = 8'hFF;
                    m_mode = M_DRAIN;
                end
            end
            default: ;
        endcase
        check_outputs(exp_load);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        if (bus.i_cs_n) m_mode = M_IDLE;
        check_outputs(1'b0);
    endtask

    task automatic cs_high();
        @(negedge clk);
        bus.i_cs_n = 1'b1;
        @(posedge clk);
        #1;
        m_mode = M_IDLE;
        check_outputs(1'b0);
    endtask

    task automatic cs_low();
        @(negedge clk);
        bus.i_cs_n = 1'b0;
    endtask

    task automatic coincident(input logic [7:0] b);
        @(negedge clk);
        bus.i_cs_n     = 1'b1;
        bus.i_rx_byte  = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
        m_mode = M_IDLE;
        check_outputs(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
        m_err  = 1'b0;
        m_cnt  = 0;
        m_addr = 0;
        m_tx   = 8'h00;
        m_mode = M_DRAIN;
        check_outputs(1'b0);
    endtask

    initial begin
        int a, n, r;
        rst            = 1'b0;
        bus.i_cs_n     = 1'b1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_byte  = 8'h00;

        do_reset();

        // write LED register
        cs_high(); cs_low();
        send_byte(8'h81); send_byte(8'h05);
        check_eq("t1_leds", leds(), 4'b0101);
        check_eq("t1_noload", bus.o_tx_load, 1'b0);

        // read burst through the whole map and run off the end
        cs_high(); cs_low();
        send_byte(8'h00); check_eq("t2_id", bus.o_tx_byte, 8'h5A);
        send_byte(8'h00); check_eq("t2_reg1", bus.o_tx_byte, 8'h05);
        send_byte(8'h00); check_eq("t2_reg2", bus.o_tx_byte, 8'h00);
        send_byte(8'h00); check_eq("t2_reg3", bus.o_tx_byte, 8'h00);
        send_byte(8'h00); check_eq("t2_runoff", bus.o_tx_byte, 8'hFF);
        check_eq("t2_runoff_load", bus.o_tx_load, 1'b1);
        send_byte(8'h00);

        // invalid command address
        cs_high(); cs_low();
        send_byte(8'h85);
        check_eq("t3_ee", bus.o_tx_byte, 8'hEE);
        check_eq("t3_err", err, 1'b1);
        send_byte(8'h12); send_byte(8'h34);
        cs_high(); cs_low();
        send_byte(8'h7F);
        check_eq("t3_status", bus.o_tx_byte, 8'h81);

        // error counter saturation and clear
        repeat (16) begin
            cs_high(); cs_low();
            send_byte(8'h80 | 8'($urandom_range(126, NUM_REGS)));
        end
        cs_high(); cs_low();
        send_byte(8'h7F);
        check_eq("t4_sat", bus.o_tx_byte, 8'h8F);
        cs_high(); cs_low();
        send_byte(8'hFF); send_byte(8'h00);
        check_eq("t4_clr_err", err, 1'b0);
        cs_high(); cs_low();
        send_byte(8'h7F);
        check_eq("t4_status0", bus.o_tx_byte, 8'h00);

        // byte coincident with CS rising is discarded
        cs_high(); cs_low();
        send_byte(8'h81); send_byte(8'h03);
        coincident(8'h0C);
        check_eq("t5_leds", leds(), 4'b0011);
        cs_low();
        send_byte(8'h01);
        check_eq("t5_rd", bus.o_tx_byte, 8'h03);

        // reset in the middle of a write burst
        cs_high(); cs_low();
        send_byte(8'h82); send_byte(8'hAA); send_byte(8'hBB);
        do_reset();
        send_byte(8'h81); send_byte(8'h0F);
        check_eq("t6_drain_leds", leds(), 4'b0000);
        cs_high(); cs_low();
        send_byte(8'h02);
        check_eq("t6_reg2", bus.o_tx_byte, 8'h00);
        cs_high(); cs_low();
        send_byte(8'h81); send_byte(8'h06);
        check_eq("t6_leds", leds(), 4'b0110);

        // write to ID is ignored without error
        cs_high(); cs_low();
        send_byte(8'h80); send_byte(8'h33);
        cs_high(); cs_low();
        send_byte(8'h00);
        check_eq("t7_id", bus.o_tx_byte, 8'h5A);
        check_eq("t7_err", err, 1'b0);

        // randomized frames
        for (int f = 0; f < 300; f++) begin
            cs_high();
            repeat ($urandom_range(2, 0)) idle_cycle();
            cs_low();
            r = $urandom_range(9, 0);
            if (r < 6)       a = $urandom_range(NUM_REGS, 0);
            else if (r < 8)  a = 127;
            else             a = $urandom_range(127, 0);
            send_byte({1'($urandom_range(1, 0)), 7'(a)});
            n = $urandom_range(6, 0);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3, 0) == 0) idle_cycle();
                send_byte(8'($urandom));
            end
            r = $urandom_range(19, 0);
            if (r == 0)      coincident(8'($urandom));
            else if (r == 1) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
